// File: rtl/bypass_rf_commit_seq.sv
// In-order commit sequencer for the bypass RF write queue: tracks allocated names,
// collects out-of-order completions and frees entries strictly in allocation order.
module bypass_rf_commit_seq #(
    parameter int name_width = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ALLOC_FIRE,
    input  logic [name_width-1:0] ALLOC_NAME,
    input  logic                  DONE_E,
    input  logic [name_width-1:0] DONE_NAME,
    output logic                  DONE_READY,
    output logic [name_width-1:0] W_F,
    output logic                  WFE,
    input  logic                  F_READY,
    input  logic                  DRAIN_REQ,
    output logic                  DRAIN_DONE,
    output logic                  ALLOC_HOLD,
    output logic [name_width:0]   COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ERR
);
    localparam int numNames = 2 ** name_width;
    localparam logic [name_width:0] FULL_CNT = (name_width + 1)'(numNames);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FIN} state_e;

    state_e                state_q;
    logic [numNames-1:0]   pending_q, pending_d;
    logic [numNames-1:0]   done_q, done_d;
    logic [name_width-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [name_width-1:0] cmt_ptr_q, cmt_ptr_d;
    logic [name_width:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic                  commit;

    assign DONE_READY = pending_q[DONE_NAME] && !done_q[DONE_NAME];
    assign W_F        = cmt_ptr_q;
    assign WFE        = pending_q[cmt_ptr_q] && done_q[cmt_ptr_q];
    assign commit     = WFE && F_READY;
    assign COUNT      = count_q;
    assign EMPTY      = (count_q == '0);
    assign FULL       = (count_q == FULL_CNT);
    assign ALLOC_HOLD = FULL || (state_q != S_IDLE);
    assign DRAIN_DONE = (state_q == S_FIN);
    assign ERR        = err_q;

    always_comb begin
        pending_d   = pending_q;
        done_d      = done_q;
        alloc_ptr_d = alloc_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        count_d     = count_q;
        err_d       = err_q;

        if (commit) begin
            pending_d[cmt_ptr_q] = 1'b0;
            done_d[cmt_ptr_q]    = 1'b0;
            cmt_ptr_d            = cmt_ptr_q + name_width'(1);
        end

        // A done on the entry being committed sees DONE_READY=0 and lands here as an error.
        if (DONE_E) begin
            if (DONE_READY) done_d[DONE_NAME] = 1'b1;
            else            err_d = 1'b1;
        end

        // Allocation is applied last so it wins over a same-name commit.
        if (ALLOC_FIRE) begin
            pending_d[ALLOC_NAME] = 1'b1;
            done_d[ALLOC_NAME]    = 1'b0;
            alloc_ptr_d           = alloc_ptr_q + name_width'(1);
            if (ALLOC_NAME != alloc_ptr_q || pending_q[ALLOC_NAME] ||
                state_q == S_DRAIN || FULL)
                err_d = 1'b1;
        end

        if (ALLOC_FIRE && !commit) begin
            if (count_q == FULL_CNT) err_d = 1'b1;
            else                     count_d = count_q + 1'b1;
        end else if (!ALLOC_FIRE && commit) begin
            if (count_q == '0) err_d = 1'b1;
            else               count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            done_q      <= '0;
            alloc_ptr_q <= '0;
            cmt_ptr_q   <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            done_q      <= done_d;
            alloc_ptr_q <= alloc_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            case (state_q)
                S_IDLE:  if (DRAIN_REQ) state_q <= S_DRAIN;
                S_DRAIN: if (count_q == '0 && !ALLOC_FIRE) state_q <= S_FIN;
                S_FIN:   state_q <= DRAIN_REQ ? S_DRAIN : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bypass_rf_commit_seq.sv
// Directed bench for bypass_rf_commit_seq: ordering, back-pressure, errors, drain, async reset.
module tb_bypass_rf_commit_seq;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       ALLOC_FIRE, DONE_E, F_READY, DRAIN_REQ;
    logic [1:0] ALLOC_NAME, DONE_NAME;
    logic       DONE_READY, WFE, DRAIN_DONE, ALLOC_HOLD, EMPTY, FULL, ERR;
    logic [1:0] W_F;
    logic [2:0] COUNT;
    int checks = 0;
    int failures = 0;

    bypass_rf_commit_seq #(.name_width(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALLOC_FIRE(ALLOC_FIRE), .ALLOC_NAME(ALLOC_NAME),
        .DONE_E(DONE_E), .DONE_NAME(DONE_NAME), .DONE_READY(DONE_READY),
        .W_F(W_F), .WFE(WFE), .F_READY(F_READY),
        .DRAIN_REQ(DRAIN_REQ), .DRAIN_DONE(DRAIN_DONE), .ALLOC_HOLD(ALLOC_HOLD),
        .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST_N = 1'b0;
        ALLOC_FIRE = 1'b0; ALLOC_NAME = '0; DONE_E = 1'b0; DONE_NAME = '0;
        F_READY = 1'b1; DRAIN_REQ = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] n);
        ALLOC_FIRE = 1'b1; ALLOC_NAME = n;
        step();
        ALLOC_FIRE = 1'b0;
    endtask

    task automatic done(input logic [1:0] n);
        DONE_E = 1'b1; DONE_NAME = n;
        step();
        DONE_E = 1'b0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        ALLOC_FIRE = 1'b0; ALLOC_NAME = '0; DONE_E = 1'b0; DONE_NAME = '0;
        F_READY = 1'b1; DRAIN_REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({WFE, W_F, DONE_READY, EMPTY, FULL, ALLOC_HOLD, DRAIN_DONE, ERR, COUNT} !==
            {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_outputs: got WFE=%b W_F=%0d DR=%b E=%b F=%b H=%b DD=%b ERR=%b CNT=%0d expected 0 0 0 1 0 0 0 0 0",
                     WFE, W_F, DONE_READY, EMPTY, FULL, ALLOC_HOLD, DRAIN_DONE, ERR, COUNT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_inorder;
        do_reset();
        alloc(0); alloc(1); alloc(2);
        checks++;
        if (COUNT !== 3'd3) begin failures++; $display("FAIL inorder_count3: got %0d expected 3", COUNT); end
        DONE_E = 1'b1; DONE_NAME = 2'd2; #1;
        checks++;
        if (DONE_READY !== 1'b1) begin failures++; $display("FAIL inorder_done_ready: got %b expected 1", DONE_READY); end
        step(); DONE_E = 1'b0;
        done(1);
        checks++;
        if (WFE !== 1'b0) begin failures++; $display("FAIL inorder_no_wfe: got %b expected 0", WFE); end
        done(0);
        checks++;
        if ({WFE, W_F, COUNT} !== {1'b1, 2'd0, 3'd3}) begin
            failures++; $display("FAIL inorder_free0: got WFE=%b W_F=%0d CNT=%0d expected 1 0 3", WFE, W_F, COUNT);
        end
        step();
        checks++;
        if ({WFE, W_F, COUNT} !== {1'b1, 2'd1, 3'd2}) begin
            failures++; $display("FAIL inorder_free1: got WFE=%b W_F=%0d CNT=%0d expected 1 1 2", WFE, W_F, COUNT);
        end
        step();
        checks++;
        if ({WFE, W_F, COUNT} !== {1'b1, 2'd2, 3'd1}) begin
            failures++; $display("FAIL inorder_free2: got WFE=%b W_F=%0d CNT=%0d expected 1 2 1", WFE, W_F, COUNT);
        end
        step();
        checks++;
        if ({WFE, W_F, COUNT, EMPTY, ERR} !== {1'b0, 2'd3, 3'd0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL inorder_empty: got WFE=%b W_F=%0d CNT=%0d EMPTY=%b ERR=%b expected 0 3 0 1 0",
                                 WFE, W_F, COUNT, EMPTY, ERR);
        end
    endtask

    task automatic test_full_wrap;
        do_reset();
        alloc(0); alloc(1); alloc(2); alloc(3);
        checks++;
        if ({FULL, ALLOC_HOLD, COUNT} !== {1'b1, 1'b1, 3'd4}) begin
            failures++; $display("FAIL full_set: got FULL=%b HOLD=%b CNT=%0d expected 1 1 4", FULL, ALLOC_HOLD, COUNT);
        end
        done(0);
        step();
        checks++;
        if ({FULL, ALLOC_HOLD, COUNT} !== {1'b0, 1'b0, 3'd3}) begin
            failures++; $display("FAIL full_release: got FULL=%b HOLD=%b CNT=%0d expected 0 0 3", FULL, ALLOC_HOLD, COUNT);
        end
        alloc(0);
        checks++;
        if ({ERR, FULL, COUNT} !== {1'b0, 1'b1, 3'd4}) begin
            failures++; $display("FAIL full_wrap_alloc: got ERR=%b FULL=%b CNT=%0d expected 0 1 4", ERR, FULL, COUNT);
        end
    endtask

    task automatic test_fready_hold;
        do_reset();
        F_READY = 1'b0;
        alloc(0); done(0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({WFE, W_F, COUNT} !== {1'b1, 2'd0, 3'd1}) begin
                failures++; $display("FAIL fready_hold_%0d: got WFE=%b W_F=%0d CNT=%0d expected 1 0 1", i, WFE, W_F, COUNT);
            end
            step();
        end
        F_READY = 1'b1;
        step();
        checks++;
        if ({WFE, W_F, COUNT} !== {1'b0, 2'd1, 3'd0}) begin
            failures++; $display("FAIL fready_commit: got WFE=%b W_F=%0d CNT=%0d expected 0 1 0", WFE, W_F, COUNT);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        alloc(0); done(0);
        alloc(1);  // commit of 0 fires on the same edge
        checks++;
        if ({COUNT, W_F, WFE, ERR} !== {3'd1, 2'd1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL b2b_alloc_commit: got CNT=%0d W_F=%0d WFE=%b ERR=%b expected 1 1 0 0", COUNT, W_F, WFE, ERR);
        end
    endtask

    task automatic test_errors;
        do_reset();
        DONE_E = 1'b1; DONE_NAME = 2'd3; #1;
        checks++;
        if (DONE_READY !== 1'b0) begin failures++; $display("FAIL err_done_ready: got %b expected 0", DONE_READY); end
        step(); DONE_E = 1'b0;
        checks++;
        if ({ERR, COUNT} !== {1'b1, 3'd0}) begin
            failures++; $display("FAIL err_bad_done: got ERR=%b CNT=%0d expected 1 0", ERR, COUNT);
        end
        do_reset();
        alloc(0);
        checks++;
        if (ERR !== 1'b0) begin failures++; $display("FAIL err_clean_alloc: got %b expected 0", ERR); end
        alloc(2);
        checks++;
        if ({ERR, COUNT} !== {1'b1, 3'd2}) begin
            failures++; $display("FAIL err_bad_name: got ERR=%b CNT=%0d expected 1 2", ERR, COUNT);
        end
        repeat (3) step();
        checks++;
        if (ERR !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", ERR); end
    endtask

    task automatic test_drain_empty;
        do_reset();
        DRAIN_REQ = 1'b1; step(); DRAIN_REQ = 1'b0;
        checks++;
        if ({ALLOC_HOLD, DRAIN_DONE} !== 2'b10) begin
            failures++; $display("FAIL drain0_enter: got HOLD=%b DD=%b expected 1 0", ALLOC_HOLD, DRAIN_DONE);
        end
        step();
        checks++;
        if (DRAIN_DONE !== 1'b1) begin failures++; $display("FAIL drain0_done: got %b expected 1", DRAIN_DONE); end
        step();
        checks++;
        if ({ALLOC_HOLD, DRAIN_DONE} !== 2'b00) begin
            failures++; $display("FAIL drain0_idle: got HOLD=%b DD=%b expected 0 0", ALLOC_HOLD, DRAIN_DONE);
        end
    endtask

    task automatic test_drain;
        int pulses;
        do_reset();
        alloc(0); alloc(1);
        DRAIN_REQ = 1'b1; step(); DRAIN_REQ = 1'b0;
        checks++;
        if (ALLOC_HOLD !== 1'b1) begin failures++; $display("FAIL drain_hold: got %b expected 1", ALLOC_HOLD); end
        done(0); done(1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (DRAIN_DONE === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL drain_pulse_count: got %0d expected 1", pulses); end
        checks++;
        if ({ALLOC_HOLD, COUNT, ERR} !== {1'b0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL drain_exit: got HOLD=%b CNT=%0d ERR=%b expected 0 0 0", ALLOC_HOLD, COUNT, ERR);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        alloc(0); alloc(1);
        DRAIN_REQ = 1'b1; step(); DRAIN_REQ = 1'b0;
        done(0);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({WFE, W_F, DONE_READY, EMPTY, FULL, ALLOC_HOLD, DRAIN_DONE, ERR, COUNT} !==
            {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL mid_reset_async: got WFE=%b W_F=%0d DR=%b E=%b F=%b H=%b DD=%b ERR=%b CNT=%0d expected 0 0 0 1 0 0 0 0 0",
                     WFE, W_F, DONE_READY, EMPTY, FULL, ALLOC_HOLD, DRAIN_DONE, ERR, COUNT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        alloc(0);
        checks++;
        if ({ERR, COUNT} !== {1'b0, 3'd1}) begin
            failures++; $display("FAIL mid_reset_realloc: got ERR=%b CNT=%0d expected 0 1", ERR, COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_inorder();
        test_full_wrap();
        test_fready_hold();
        test_back_to_back();
        test_errors();
        test_drain_empty();
        test_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bypass_rf_commit_seq.md
Name: bypass_rf_commit_seq

Overview:
- In-order commit sequencer for the bypass register file's write queue.
- Tracks every write name the allocator reserves, accepts out-of-order "write done" notifications from pipeline stages, and issues frees (W_F/WFE) strictly in allocation order, so the RF's owner-pointer check is always satisfied.
- Provides occupancy status, allocation back-pressure and a drain handshake for pipeline quiesce.

Parameters:
- name_width, 2, width of a write-queue name.
- numNames, 2**name_width, number of write-queue entries.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- ALLOC_FIRE  in  1  the RF accepted an allocation this cycle (ALLOC_E && ALLOC_READY).
- ALLOC_NAME  in  name_width  name returned by the RF for that allocation.
- DONE_E  in  1  a stage reports its write to DONE_NAME is complete.
- DONE_NAME  in  name_width  name being reported done.
- DONE_READY  out  1  DONE_NAME is allocated and not already done.
- W_F  out  name_width  name to free; drives the RF free port.
- WFE  out  1  free request to the RF.
- F_READY  in  1  RF free-ready (owner match).
- DRAIN_REQ  in  1  request to quiesce (one-cycle pulse or level).
- DRAIN_DONE  out  1  one-cycle pulse: all entries committed.
- ALLOC_HOLD  out  1  allocators must not allocate.
- COUNT  out  name_width+1  outstanding entries.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==numNames.
- ERR  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - pending[] and done[] cleared; allocPtr=0, cmtPtr=0, COUNT=0; FSM=IDLE.
  - Outputs: WFE=0, W_F=0, DONE_READY=0, EMPTY=1, FULL=0, ALLOC_HOLD=0, DRAIN_DONE=0, ERR=0.
  - Reset mid-operation discards all tracking state.
- Allocation:
  - On ALLOC_FIRE: set pending[ALLOC_NAME], clear done[ALLOC_NAME], allocPtr++ (wraps mod numNames).
  - ERR is set if any of the following hold:
    - ALLOC_NAME != allocPtr;
    - pending[ALLOC_NAME] was already set;
    - FSM is DRAIN;
    - FULL.
  - An erroneous allocation is still recorded.
- Done:
  - DONE_READY = pending[DONE_NAME] && !done[DONE_NAME] (combinational).
  - On DONE_E && DONE_READY: set done[DONE_NAME].
  - DONE_E && !DONE_READY sets ERR; state is unchanged.
- Commit:
  - W_F = cmtPtr; WFE = pending[cmtPtr] && done[cmtPtr] (combinational from registers). Minimum latency from done to WFE is one cycle.
  - Fire on WFE && F_READY: clear pending/done[cmtPtr], cmtPtr++ (wraps). At most one commit per cycle.
  - WFE holds while F_READY=0.
- Simultaneous events:
  - ALLOC_FIRE and a commit in the same cycle: COUNT unchanged.
  - Alloc and commit on the same name cannot occur legally (the RF gates alloc on a free entry); if it does, the alloc wins and ERR is set.
  - DONE on cmtPtr in the same cycle a commit fires is illegal (the entry is already done) and sets ERR.
- Status:
  - COUNT = COUNT + ALLOC_FIRE − commit, saturating at 0 and numNames (saturation sets ERR).
  - EMPTY/FULL are decoded from the registered COUNT.
- Drain FSM:
  - IDLE: DRAIN_REQ → DRAIN.
  - DRAIN: when COUNT==0 and no ALLOC_FIRE this cycle → FIN. DRAIN_REQ is ignored while in DRAIN.
  - FIN: DRAIN_DONE=1 for one cycle → IDLE. If DRAIN_REQ is high in FIN, re-enter DRAIN next cycle.
  - ALLOC_HOLD = FULL || (FSM != IDLE), registered-state decode.
  - Entering DRAIN with COUNT already 0 gives a DRAIN_DONE two cycles after DRAIN_REQ.
- ERR: sticky until reset.

Test Plan:
- Reset, then alloc names 0,1,2; DONE 2, then 1 → no WFE. DONE 0 → next cycle WFE=1/W_F=0; with F_READY=1, frees 0,1,2 on consecutive cycles; COUNT 3→0, EMPTY=1.
- numNames=4: alloc 4 entries → FULL=1, ALLOC_HOLD=1. Commit one → FULL=0, HOLD=0. Alloc name 0 (wrap) accepted, ERR=0.
- Entry 0 done with F_READY=0 for 3 cycles → WFE held high with W_F=0 and no pointer move; F_READY=1 → commit in that cycle.
- Protocol errors:
  - DONE_NAME=3 when not allocated → DONE_READY=0, ERR=1.
  - ALLOC_NAME=2 when allocPtr=1 → ERR=1.
- Drain: alloc 0,1; DRAIN_REQ → ALLOC_HOLD=1 next cycle. DONE 0,1; after both commits, DRAIN_DONE pulses exactly once, then HOLD=0.
- Assert RST_N low mid-drain with COUNT=2 → all outputs at reset values immediately (async); after release, alloc name 0 is accepted with no ERR.
